// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// opcodes, ALU/PC select codes and the decoded control word.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPEEX  = 4'd7,
        RTYPEWB  = 4'd8,
        BEQEX    = 4'd9,
        ADDIEX   = 4'd10,
        ADDIWB   = 4'd11,
        JEX      = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath plus memory port (slave).
interface multicycle_controller_if;
    logic [5:0] OpCode;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCEn;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       RegDest;
    logic       MemtoReg;
    logic       illegal_op;

    modport master (
        input  OpCode, Zero, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCEn, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDest, MemtoReg, illegal_op
    );

    modport slave (
        output OpCode, Zero, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, PCWrite, PCEn, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDest, MemtoReg, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state-to-control-word decoder (Moore part of the controller); the
// handshake qualification of FETCH writes is applied by the parent.
module mc_ctrl_outdec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cw_o = '0;
        case (state_i)
            FETCH: begin
                cw_o.mem_req   = 1'b1;
                cw_o.ir_write  = 1'b1;
                cw_o.pc_write  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.alu_op    = ALUOP_ADD;
                cw_o.pc_src    = PCSRC_ALU;
            end
            DECODE: begin
                // Speculative branch target into ALUOut
                cw_o.alu_src_b = SRCB_IMM_SL2;
                cw_o.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                cw_o.mem_req = 1'b1;
                cw_o.iord    = 1'b1;
            end
            MEMWB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                cw_o.mem_req   = 1'b1;
                cw_o.iord      = 1'b1;
                cw_o.mem_write = 1'b1;
            end
            RTYPEEX: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_RT;
                cw_o.alu_op    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                cw_o.reg_write = 1'b1;
                cw_o.reg_dest  = 1'b1;
            end
            ADDIWB:  cw_o.reg_write = 1'b1;
            BEQEX: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_RT;
                cw_o.alu_op    = ALUOP_SUB;
                cw_o.branch    = 1'b1;
                cw_o.pc_src    = PCSRC_ALUOUT;
            end
            JEX: begin
                cw_o.pc_write = 1'b1;
                cw_o.pc_src   = PCSRC_JUMP;
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (lw/sw/R-type/addi/beq/j) with ready-stretched
// memory states. Define MULTICYCLE_CTRL_PERF_EN to add cycle/instruction counters.
module multicycle_controller
    import multicycle_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    multicycle_controller_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state_q, state_d;
    ctrl_word_t cw;
    logic       illegal;
    logic       fetch_done;
    logic       pc_write;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.OpCode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (bus.OpCode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (bus.mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (bus.mem_ready) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .cw_o    (cw)
    );

    // IR/PC loads in FETCH only commit once memory has returned the word
    assign fetch_done = (state_q != FETCH) || bus.mem_ready;
    assign pc_write   = cw.pc_write & fetch_done;

    assign bus.mem_req    = cw.mem_req;
    assign bus.IorD       = cw.iord;
    assign bus.MemWrite   = cw.mem_write;
    assign bus.IRWrite    = cw.ir_write & fetch_done;
    assign bus.PCWrite    = pc_write;
    assign bus.Branch     = cw.branch;
    assign bus.PCEn       = pc_write | (cw.branch & bus.Zero);
    assign bus.PCSrc      = cw.pc_src;
    assign bus.ALUSrcA    = cw.alu_src_a;
    assign bus.ALUSrcB    = cw.alu_src_b;
    assign bus.ALUOp      = cw.alu_op;
    assign bus.RegWrite   = cw.reg_write;
    assign bus.RegDest    = cw.reg_dest;
    assign bus.MemtoReg   = cw.mem_to_reg;
    assign bus.illegal_op = illegal;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != IDLE)
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            // A FETCH that is merely holding for mem_ready is not a new instruction
            if (state_d == FETCH && state_q != IDLE && state_q != FETCH)
                instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle compare of all control
// outputs against a step-table model, plus literal pins on reset/CPI/abort.
module tb_multicycle_controller;

    typedef enum int {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
        ST_RTYPEEX, ST_RTYPEWB, ST_BEQEX, ST_ADDIEX, ST_ADDIWB, ST_JEX
    } step_e;

    typedef struct packed {
        logic       mem_req, iord, mem_write, ir_write, pc_write, pc_en, branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_write, reg_dest, mem_to_reg, illegal;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    multicycle_controller_if bus ();
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_cyc  = 0;
    logic  chk_en = 1'b0;
    step_e exp_step;
    obs_t  exp_w;
    obs_t  act_w;
    logic [5:0] cur_op;
    logic       cur_zero;

    assign act_w = '{bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCEn,
                     bus.Branch, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                     bus.RegWrite, bus.RegDest, bus.MemtoReg, bus.illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs for one step of an instruction, straight from the control table
    function automatic obs_t model(step_e s, logic rdy, logic z, logic [5:0] op);
        obs_t w = '0;
        case (s)
            ST_FETCH:   begin w.mem_req = 1; w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
            ST_DECODE:  begin
                w.alu_src_b = 2'b11;
                w.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010});
            end
            ST_MEMADR,
            ST_ADDIEX:  begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
            ST_MEMRD:   begin w.mem_req = 1; w.iord = 1; end
            ST_MEMWB:   begin w.reg_write = 1; w.mem_to_reg = 1; end
            ST_MEMWR:   begin w.mem_req = 1; w.iord = 1; w.mem_write = 1; end
            ST_RTYPEEX: begin w.alu_src_a = 1; w.alu_op = 2'b10; end
            ST_RTYPEWB: begin w.reg_write = 1; w.reg_dest = 1; end
            ST_ADDIWB:  w.reg_write = 1;
            ST_BEQEX:   begin w.alu_src_a = 1; w.alu_op = 2'b01; w.branch = 1; w.pc_src = 2'b01; end
            ST_JEX:     begin w.pc_write = 1; w.pc_src = 2'b10; end
            default:    w = '0;
        endcase
        w.pc_en = w.pc_write | (w.branch & z);
        return w;
    endfunction

    always @(negedge clk)
        if (chk_en) check($sformatf("cw_%s", exp_step.name()), 32'(act_w), 32'(exp_w));

    task automatic drive(input step_e s, input logic rdy);
        bus.mem_ready = rdy;
        bus.OpCode    = cur_op;
        bus.Zero      = cur_zero;
        exp_step      = s;
        exp_w         = model(s, rdy, cur_zero, cur_op);
        chk_en        = 1'b1;
    endtask

    task automatic cycle(input step_e s, input logic rdy);
        drive(s, rdy);
        n_cyc++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // mem_ready toggles in non-memory steps; the controller must ignore it there
    function automatic logic junk_rdy();
        return 1'(n_cyc & 1);
    endfunction

    task automatic run_tail(input logic [5:0] op, input logic z, input int mw);
        cur_op   = op;
        cur_zero = z;
        cycle(ST_DECODE, junk_rdy());
        case (op)
            6'b100011: begin
                cycle(ST_MEMADR, junk_rdy());
                repeat (mw) cycle(ST_MEMRD, 1'b0);
                cycle(ST_MEMRD, 1'b1);
                cycle(ST_MEMWB, junk_rdy());
            end
            6'b101011: begin
                cycle(ST_MEMADR, junk_rdy());
                repeat (mw) cycle(ST_MEMWR, 1'b0);
                cycle(ST_MEMWR, 1'b1);
            end
            6'b000000: begin cycle(ST_RTYPEEX, junk_rdy()); cycle(ST_RTYPEWB, junk_rdy()); end
            6'b001000: begin cycle(ST_ADDIEX, junk_rdy());  cycle(ST_ADDIWB, junk_rdy());  end
            6'b000100: cycle(ST_BEQEX, junk_rdy());
            6'b000010: cycle(ST_JEX, junk_rdy());
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int cpi, input string name);
        int n0 = n_cyc;
        cur_op   = op;
        cur_zero = z;
        repeat (fw) cycle(ST_FETCH, 1'b0);
        cycle(ST_FETCH, 1'b1);
        run_tail(op, z, mw);
        check({"cpi_", name}, n_cyc - n0, cpi);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1;
        cur_op = 6'b000000;
        cur_zero = 1'b0;
        bus.OpCode = 6'b000000;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Release reset: one IDLE cycle with everything low, then FETCH with writes
        rst = 1'b0;
        drive(ST_IDLE, 1'b1);
        @(negedge clk);
        check("rst_idle_all_zero", 32'(act_w), 32'h0);
        @(posedge clk); #1;

        n0 = n_cyc;
        cur_op = 6'b001000;
        drive(ST_FETCH, 1'b1);
        n_cyc++;
        @(negedge clk);
        check("first_fetch_ir_pc_write", {30'b0, bus.IRWrite, bus.PCWrite}, 32'h3);
        @(posedge clk); #1;
        run_tail(6'b001000, 1'b0, 0);
        check("cpi_addi", n_cyc - n0, 4);

        run_instr(6'b100011, 1'b0, 0, 2, 7, "lw_wait2");
        run_instr(6'b101011, 1'b0, 1, 1, 6, "sw_wait");
        run_instr(6'b100011, 1'b1, 0, 0, 5, "lw");
        run_instr(6'b101011, 1'b0, 0, 0, 4, "sw");
        run_instr(6'b000000, 1'b1, 0, 0, 4, "rtype");
        run_instr(6'b000100, 1'b1, 0, 0, 3, "beq_taken");
        run_instr(6'b000100, 1'b0, 0, 0, 3, "beq_not_taken");
        run_instr(6'b000010, 1'b0, 2, 0, 5, "j_fetch_wait");
        run_instr(6'b111111, 1'b1, 0, 0, 2, "illegal_3f");
        run_instr(6'b000001, 1'b0, 0, 0, 2, "illegal_01");

        // Reset while a store waits on memory: request must drop the next cycle
        cur_op = 6'b101011;
        cur_zero = 1'b0;
        cycle(ST_FETCH, 1'b1);
        cycle(ST_DECODE, 1'b1);
        cycle(ST_MEMADR, 1'b0);
        cycle(ST_MEMWR, 1'b0);
        rst = 1'b1;
        cycle(ST_MEMWR, 1'b0);
        rst = 1'b0;
        drive(ST_IDLE, 1'b0);
        @(negedge clk);
        check("rst_abort_req_dropped", {30'b0, bus.mem_req, bus.MemWrite}, 32'h0);
        @(posedge clk); #1;
        run_instr(6'b001000, 1'b0, 0, 0, 4, "addi_after_abort");

`ifdef MULTICYCLE_CTRL_PERF_EN
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(ST_IDLE, 1'b1);
        run_instr(6'b000000, 1'b0, 0, 0, 4, "perf_rtype");
        run_instr(6'b000010, 1'b0, 0, 0, 3, "perf_j");
        cur_op = 6'b000010;
        drive(ST_FETCH, 1'b0);
        @(negedge clk);
        check("perf_instr_cnt", instr_cnt, 32'd2);
        check("perf_cycle_cnt", cycle_cnt, 32'd7);
        @(posedge clk); #1;

        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        release dut.cycle_cnt_q;
        cycle(ST_FETCH, 1'b0);
        drive(ST_FETCH, 1'b0);
        @(negedge clk);
        check("perf_cycle_wrap", cycle_cnt, 32'd0);
        @(posedge clk); #1;

        force dut.instr_cnt_q = 32'hFFFF_FFFF;
        release dut.instr_cnt_q;
        run_instr(6'b000010, 1'b0, 0, 0, 3, "perf_wrap_j");
        drive(ST_FETCH, 1'b0);
        @(negedge clk);
        check("perf_instr_wrap", instr_cnt, 32'd0);
        @(posedge clk); #1;
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state control unit for the multi-cycle variant of the 32-bit MIPS core. It sequences one shared ALU, a unified instruction/data memory port, the IR, the register file and the PC across several cycles per instruction. It replaces the combinational opcode decoder for the subset lw, sw, R-type, addi, beq and j. A ready-qualified memory handshake stretches the memory states.

## Interface
- No parameters.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- OpCode  in  6  IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  write strobe, valid with mem_req
- IRWrite  out  1  load IR
- PCWrite  out  1  unconditional PC load
- PCEn  out  1  PCWrite | (Branch & Zero)
- Branch  out  1  conditional PC load
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct
- RegWrite, RegDest, MemtoReg  out  1 each  same meaning as single-cycle core
- illegal_op  out  1  one-cycle pulse on unsupported opcode

## Operation
- States (4-bit encoding): IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- IDLE: all outputs 0, then FETCH.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite assert only when mem_ready=1. The state holds while mem_ready=0 and advances to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Next state by OpCode:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 001000 → ADDIEX
  - 000100 → BEQEX
  - 000010 → JEX
  - any other → FETCH, with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDest=0. Then FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1. Holds until mem_ready, then FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RTYPEWB (RegWrite=1, RegDest=1, MemtoReg=0), then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDIWB (RegWrite=1, RegDest=0, MemtoReg=0), then FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01. Then FETCH.
- JEX: PCWrite=1, PCSrc=10. Then FETCH.
- Any output not listed for a state is 0. Outputs are decoded from the registered state; only IRWrite/PCWrite in FETCH are additionally qualified by mem_ready.
- Unreachable state encodings go to IDLE with all outputs 0.

## Timing
- Reset: state=IDLE on the first rising edge with rst=1. Every output is 0 while in IDLE. FETCH is entered on the first edge after rst deasserts.
- rst mid-instruction: the instruction is aborted with no further writes; any pending memory request is dropped next cycle.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_req, IorD and MemWrite stay stable through the whole wait.
- mem_ready outside memory states is ignored.

## Configuration
- MULTICYCLE_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-IDLE cycle.
  - instr_cnt increments on each transition into FETCH from a non-IDLE state.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: no counters or ports; the rest is identical.

## Structure
- Package multicycle_ctrl_pkg holds:
  - the state typedef and encodings
  - the opcode constants (LW, SW, RTYPE, ADDI, BEQ, J)
  - the ALUOp, ALUSrcB and PCSrc constants
- One sub-module, mc_ctrl_outdec: combinational state-to-control-word decoder.
- multicycle_controller owns the state register, next-state logic, handshake qualification and the optional counters.

## Test plan
- Reset, then release with mem_ready=1 → IDLE for one cycle with all outputs 0, then FETCH with IRWrite=PCWrite=1.
- lw (OpCode 100011), mem_ready=0 for 2 cycles in MEMRD → states FETCH, DECODE, MEMADR, MEMRD×3, MEMWB. RegWrite=MemtoReg=1 only in MEMWB. Total 7 cycles.
- beq with Zero=1, then with Zero=0 → PCEn=1 in BEQEX for the first, 0 for the second. Both take 3 cycles.
- OpCode 111111 → illegal_op pulses in DECODE, back to FETCH, no RegWrite, MemWrite or PCEn asserted.
- rst asserted during MEMWR while mem_ready=0 → next cycle IDLE, mem_req=0, MemWrite=0.
- With MULTICYCLE_CTRL_PERF_EN: R-type then j, zero waits → instr_cnt=2, cycle_cnt=7. Counters preset near 0xFFFFFFFF wrap to 0.
